// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// register-index width and the per-stage enable/flush control bundle.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } ctl_t;

  // Control patterns: a stage loads a bubble only when both en and flush are set
  localparam ctl_t CTL_HOLD    = ctl_t'(9'b0_00_00_00_00);
  localparam ctl_t CTL_DMEM    = ctl_t'(9'b0_00_00_00_11);
  localparam ctl_t CTL_HALT    = ctl_t'(9'b0_11_11_11_10);
  localparam ctl_t CTL_BRANCH  = ctl_t'(9'b1_11_11_10_10);
  localparam ctl_t CTL_LOADUSE = ctl_t'(9'b0_00_11_10_10);
  localparam ctl_t CTL_IMEM    = ctl_t'(9'b0_11_10_10_10);
  localparam ctl_t CTL_RUN     = ctl_t'(9'b1_10_10_10_10);

  function automatic logic load_use_hit(
    input logic                 memread,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs,
    input logic                 rs_vld,
    input logic [REG_IDX_W-1:0] rt,
    input logic                 rt_vld
  );
    return memread && ((rs_vld && (rs == rd)) || (rt_vld && (rt == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: prioritised hazard
// resolution, dmem-stall timeout, halt draining and performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic                 id_rs_vld,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_rt_vld,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 branch_taken,
  input  logic                 imem_stall,
  input  logic                 dmem_stall,
  input  logic                 halt_mem,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 exmem_flush,
  output logic                 memwb_en,
  output logic                 memwb_flush,
  output logic                 halted,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic          r_halted;
  logic          r_err;

  ctl_t w_ctl;
  logic w_active;
  logic w_load_use;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_active   = !rst && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));
  assign w_load_use = load_use_hit(ex_memread, ex_rd, id_rs, id_rs_vld, id_rt, id_rt_vld);

  always_comb begin
    w_ctl = CTL_HOLD;
    if (w_active) begin
      if (dmem_stall)        w_ctl = CTL_DMEM;
      else if (halt_mem)     w_ctl = CTL_HALT;
      else if (branch_taken) w_ctl = CTL_BRANCH;
      else if (w_load_use)   w_ctl = CTL_LOADUSE;
      else if (imem_stall)   w_ctl = CTL_IMEM;
      else                   w_ctl = CTL_RUN;
    end
  end

  // r_tmo counts stalled cycles already elapsed; it is always 0 in RUN, so the
  // MEM_TIMEOUT-th consecutive stalled cycle is the one that sees TMO_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_tmo    <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (dmem_stall) begin
            if (r_tmo == TMO_LAST) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
              r_err    <= 1'b1;
            end else begin
              r_state <= ST_MEM_WAIT;
              r_tmo   <= r_tmo + 1'b1;
            end
          end else begin
            r_tmo   <= '0;
            r_state <= halt_mem ? ST_DRAIN : ST_RUN;
          end
        end
        ST_DRAIN: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  assign w_stall_inc = w_active && !w_ctl.pc_en;
  assign w_flush_inc = w_active && !dmem_stall && !halt_mem && branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_stall_inc),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_flush_inc),
    .q   (flush_count)
  );

  assign pc_en       = w_ctl.pc_en;
  assign ifid_en     = w_ctl.ifid_en;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_en     = w_ctl.idex_en;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_en    = w_ctl.exmem_en;
  assign exmem_flush = w_ctl.exmem_flush;
  assign memwb_en    = w_ctl.memwb_en;
  assign memwb_flush = w_ctl.memwb_flush;
  assign halted      = r_halted;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_rs_vld, id_rt_vld, ex_memread, branch_taken;
  logic       imem_stall, dmem_stall, halt_mem;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
  logic        halted, err_timeout;
  logic [15:0] stall_cycles, flush_count;

  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
  logic        b_exmem_en, b_exmem_flush, b_memwb_en, b_memwb_flush;
  logic        b_halted, b_err_timeout;
  logic [2:0]  b_stall_cycles, b_flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halted(halted), .err_timeout(err_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Short timeout and narrow counters so timeout and saturation are reachable
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
    .idex_en(b_idex_en), .idex_flush(b_idex_flush),
    .exmem_en(b_exmem_en), .exmem_flush(b_exmem_flush),
    .memwb_en(b_memwb_en), .memwb_flush(b_memwb_flush),
    .halted(b_halted), .err_timeout(b_err_timeout),
    .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
  );

  logic [8:0] ctl_a, ctl_b;
  assign ctl_a = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, memwb_flush};
  assign ctl_b = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush,
                  b_exmem_en, b_exmem_flush, b_memwb_en, b_memwb_flush};

  // {pc_en, ifid en/flush, idex en/flush, exmem en/flush, memwb en/flush}
  localparam logic [8:0] E_OFF  = 9'b0_00_00_00_00;
  localparam logic [8:0] E_DMEM = 9'b0_00_00_00_11;
  localparam logic [8:0] E_HALT = 9'b0_11_11_11_10;
  localparam logic [8:0] E_BR   = 9'b1_11_11_10_10;
  localparam logic [8:0] E_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] E_IMEM = 9'b0_11_10_10_10;
  localparam logic [8:0] E_RUN  = 9'b1_10_10_10_10;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs;
    logic       rsv;
    logic [2:0] rt;
    logic       rtv;
    logic [2:0] rd;
    logic       mr, br, im, dm, hm;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [8:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; id_rs = v.rs; id_rs_vld = v.rsv; id_rt = v.rt; id_rt_vld = v.rtv;
    ex_rd = v.rd; ex_memread = v.mr; branch_taken = v.br;
    imem_stall = v.im; dmem_stall = v.dm; halt_mem = v.hm;
  endtask

  function automatic in_t mk(input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                             input logic rtv, input logic [2:0] rd, input logic mr,
                             input logic br, input logic im, input logic dm, input logic hm);
    in_t v;
    v = '0;
    v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv; v.rd = rd;
    v.mr = mr; v.br = br; v.im = im; v.dm = dm; v.hm = hm;
    return v;
  endfunction

  // Drive v, then sample at the falling edge; the caller checks and calls adv().
  task automatic apply(input in_t v);
    drive(v);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_t v;
    v = '0;
    v.rst = 1'b1;
    drive(v);
    adv();
    adv();
    drive('0);
  endtask

  // Reference model: tracks halted/draining flags and the length of the
  // current dmem-stall run rather than any state encoding.
  int m_off[2], m_err[2], m_drain[2], m_run[2], m_stall[2], m_flush[2];
  int m_tmo[2]  = '{64, 4};
  int m_max[2]  = '{65535, 7};

  function automatic logic [8:0] ref_ctl(input int k, input in_t v);
    logic lu;
    if (v.rst || m_off[k] != 0 || m_drain[k] != 0) return E_OFF;
    lu = v.mr && ((v.rsv && v.rs == v.rd) || (v.rtv && v.rt == v.rd));
    if (v.dm) return E_DMEM;
    if (v.hm) return E_HALT;
    if (v.br) return E_BR;
    if (lu)   return E_LU;
    if (v.im) return E_IMEM;
    return E_RUN;
  endfunction

  task automatic ref_step(input int k, input in_t v);
    logic [8:0] c;
    c = ref_ctl(k, v);
    if (v.rst) begin
      m_off[k] = 0; m_err[k] = 0; m_drain[k] = 0; m_run[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
    end else if (m_off[k] != 0) begin
      m_off[k] = 1;
    end else if (m_drain[k] != 0) begin
      m_drain[k] = 0;
      m_off[k]   = 1;
    end else begin
      if (!c[8] && m_stall[k] < m_max[k]) m_stall[k]++;
      if (v.dm) begin
        m_run[k]++;
        if (m_run[k] == m_tmo[k]) begin
          m_off[k] = 1;
          m_err[k] = 1;
        end
      end else begin
        m_run[k] = 0;
        if (v.hm) m_drain[k] = 1;
        else if (v.br && m_flush[k] < m_max[k]) m_flush[k]++;
      end
    end
  endtask

  initial begin
    in_t  v;
    in_t  lu;
    vec_t tbl[10];
    logic dm_prev;

    tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_RUN};
    tbl[1] = '{mk(3, 1, 0, 0, 3, 1, 0, 0, 0, 0), E_LU};
    tbl[2] = '{mk(3, 0, 0, 0, 3, 1, 0, 0, 0, 0), E_RUN};
    tbl[3] = '{mk(5, 0, 5, 1, 5, 1, 0, 0, 0, 0), E_LU};
    tbl[4] = '{mk(5, 0, 4, 1, 5, 1, 0, 0, 0, 0), E_RUN};
    tbl[5] = '{mk(2, 1, 2, 1, 2, 0, 0, 0, 0, 0), E_RUN};
    tbl[6] = '{mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), E_IMEM};
    tbl[7] = '{mk(7, 1, 0, 0, 7, 1, 0, 1, 0, 0), E_LU};
    tbl[8] = '{mk(7, 1, 0, 0, 7, 1, 1, 1, 0, 0), E_BR};
    tbl[9] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), E_BR};
    lu = mk(3, 1, 0, 0, 3, 1, 0, 0, 0, 0);

    // Reset with busy inputs: everything off
    v = mk(3, 1, 3, 1, 3, 1, 1, 1, 1, 1);
    v.rst = 1'b1;
    drive(v);
    adv();
    apply(v);
    chk("rst_ctl", ctl_a, E_OFF);
    chk("rst_halted", halted, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_flush_cnt", flush_count, 0);
    adv();
    apply('0);
    chk("post_rst_idle", ctl_a, E_RUN);
    adv();

    foreach (tbl[i]) begin
      apply(tbl[i].i);
      chk($sformatf("vec%0d", i), ctl_a, tbl[i].exp);
      adv();
    end

    // Load-use for one cycle, then same with rs not read
    do_reset();
    apply(lu);
    chk("lu_ctl", ctl_a, E_LU);
    adv();
    apply('0);
    chk("lu_stall_cnt", stall_cycles, 1);
    adv();
    v = lu; v.rsv = 1'b0;
    apply(v);
    chk("lu_novld_ctl", ctl_a, E_RUN);
    adv();
    apply('0);
    chk("lu_novld_cnt", stall_cycles, 1);
    adv();

    // Branch overrides imem stall and load-use
    do_reset();
    v = lu; v.br = 1'b1; v.im = 1'b1;
    apply(v);
    chk("br_ctl", ctl_a, E_BR);
    adv();
    apply('0);
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_cycles, 0);
    adv();

    // dmem stall for 5 cycles with a held branch
    do_reset();
    for (int c = 0; c < 5; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      chk($sformatf("dmem_ctl%0d", c), ctl_a, E_DMEM);
      adv();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("dmem_release_br", ctl_a, E_BR);
    adv();
    apply('0);
    chk("dmem_run_ctl", ctl_a, E_RUN);
    chk("dmem_stall_cnt", stall_cycles, 5);
    chk("dmem_flush_cnt", flush_count, 1);
    chk("dmem_not_halted", halted, 0);
    adv();

    // Short-timeout instance: 3 stalled cycles survive, 4 trip the timeout
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      adv();
    end
    apply('0);
    chk("tmo3_ctl", ctl_b, E_RUN);
    chk("tmo3_halted", b_halted, 0);
    adv();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      chk($sformatf("tmo_ctl%0d", c), ctl_b, E_DMEM);
      chk($sformatf("tmo_halted%0d", c), b_halted, 0);
      adv();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("tmo_off_ctl", ctl_b, E_OFF);
    chk("tmo_halted", b_halted, 1);
    chk("tmo_err", b_err_timeout, 1);
    chk("tmo_stall_cnt", b_stall_cycles, 4);
    adv();
    apply('0);
    chk("tmo_off_ctl2", ctl_b, E_OFF);
    adv();

    // Halt: squash, drain, halted
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    chk("halt_ctl", ctl_a, E_HALT);
    adv();
    apply('0);
    chk("drain_ctl", ctl_a, E_OFF);
    chk("drain_halted", halted, 0);
    adv();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    chk("halted_ctl", ctl_a, E_OFF);
    chk("halted_flag", halted, 1);
    chk("halted_err", err_timeout, 0);
    chk("halt_stall_cnt", stall_cycles, 1);
    adv();

    // Reset out of HALTED
    v = '0; v.rst = 1'b1;
    apply(v);
    chk("rst_halted_ctl", ctl_a, E_OFF);
    adv();
    apply('0);
    chk("rst_halted_run", ctl_a, E_RUN);
    chk("rst_halted_flag", halted, 0);
    adv();

    // Halt arriving during a dmem stall waits for the stall to clear
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      chk($sformatf("halt_dmem%0d", c), ctl_a, E_DMEM);
      adv();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("halt_after_dmem", ctl_a, E_HALT);
    adv();
    apply('0);
    chk("halt_after_drain", ctl_a, E_OFF);
    adv();

    // Reset while in MEM_WAIT
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      adv();
    end
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); v.rst = 1'b1;
    apply(v);
    chk("rst_mw_ctl", ctl_a, E_OFF);
    adv();
    apply('0);
    chk("rst_mw_run", ctl_a, E_RUN);
    chk("rst_mw_stall_cnt", stall_cycles, 0);
    chk("rst_mw_err", err_timeout, 0);
    adv();

    // Narrow counter saturates at all-ones
    do_reset();
    for (int c = 0; c < 9; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      adv();
    end
    apply('0);
    chk("sat_stall_cnt", b_stall_cycles, 7);
    adv();

    // Randomized run against the reference model
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_off[k] = 0; m_err[k] = 0; m_drain[k] = 0; m_run[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
    end
    dm_prev = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      v.rst = ($urandom_range(99) < 2) ||
              ((m_off[0] != 0 || m_off[1] != 0) && $urandom_range(7) == 0);
      v.rs  = 3'($urandom_range(7));
      v.rt  = 3'($urandom_range(7));
      v.rd  = 3'($urandom_range(7));
      v.rsv = 1'($urandom_range(1));
      v.rtv = 1'($urandom_range(1));
      v.mr  = 1'($urandom_range(1));
      v.br  = ($urandom_range(3) == 0);
      v.im  = ($urandom_range(3) == 0);
      v.hm  = ($urandom_range(29) == 0);
      v.dm  = dm_prev ? ($urandom_range(9) < 8) : ($urandom_range(9) < 2);
      dm_prev = v.dm;
      apply(v);
      chk("rnd_ctl_a", ctl_a, ref_ctl(0, v));
      chk("rnd_halted_a", halted, m_off[0] != 0);
      chk("rnd_err_a", err_timeout, m_err[0] != 0);
      chk("rnd_stall_a", stall_cycles, m_stall[0]);
      chk("rnd_flush_a", flush_count, m_flush[0]);
      chk("rnd_ctl_b", ctl_b, ref_ctl(1, v));
      chk("rnd_halted_b", b_halted, m_off[1] != 0);
      chk("rnd_err_b", b_err_timeout, m_err[1] != 0);
      chk("rnd_stall_b", b_stall_cycles, m_stall[1]);
      chk("rnd_flush_b", b_flush_count, m_flush[1]);
      ref_step(0, v);
      ref_step(1, v);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage 16-bit pipeline. Drives the en/flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves load-use hazards, taken-branch squashes, multi-cycle instruction/data memory stalls and halt draining. Stall and flush outputs are combinational from state and inputs. Its FSM, timeout counter and performance counters are registered.

Parameters:
MEM_TIMEOUT, 64, max consecutive dmem_stall cycles before error halt (>=2)
CNT_W, 16, width of performance counters (saturating)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_rs  in  3  source reg A of instruction in ID
id_rs_vld  in  1  id_rs is actually read
id_rt  in  3  source reg B of instruction in ID
id_rt_vld  in  1  id_rt is actually read
ex_rd  in  3  dest reg of instruction in EX
ex_memread  in  1  EX instruction is a load (valid-qualified)
branch_taken  in  1  EX resolved a redirect (branch/jump taken)
imem_stall  in  1  instruction memory busy this cycle
dmem_stall  in  1  data memory busy for MEM-stage access
halt_mem  in  1  valid HALT instruction in MEM stage
pc_en  out  1  PC write enable
ifid_en, ifid_flush  out  1 each  IF/ID control
idex_en, idex_flush  out  1 each  ID/EX control
exmem_en, exmem_flush  out  1 each  EX/MEM control
memwb_en, memwb_flush  out  1 each  MEM/WB control
halted  out  1  core halted (normal or error)
err_timeout  out  1  halted due to dmem timeout
stall_cycles  out  CNT_W  cycles with pc_en=0 in RUN/MEM_WAIT
flush_count  out  CNT_W  number of branch squashes

Behaviour:
- Reset: state=RUN, timeout counter=0, halted=0, err_timeout=0, counters=0. While rst=1, all en and flush outputs are 0.
- Flush semantics: a register loads a bubble only when en=1 and flush=1. flush with en=0 is never driven.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- Priority in RUN/MEM_WAIT, highest first:
  - (1) dmem_stall: pc, ifid, idex and exmem hold (en=0). memwb_en=1 and memwb_flush=1 (bubble to WB). RUN->MEM_WAIT. In MEM_WAIT the timeout counter increments each stalled cycle. When it reaches MEM_TIMEOUT-1 while dmem_stall is still 1, next state=HALTED with err_timeout=1. When dmem_stall drops, MEM_WAIT->RUN, counter=0, and that cycle is evaluated at priority (2) onward.
  - (2) halt_mem, when dmem_stall=0: pc_en=0; ifid, idex and exmem each get en=1 and flush=1 (squash younger instructions); memwb_en=1 and memwb_flush=0 (HALT retires). Next state=DRAIN.
  - (3) branch_taken: pc_en=1 (redirect, overrides imem_stall); ifid and idex flush with en=1; exmem and memwb advance. flush_count +1.
  - (4) load-use, i.e. ex_memread and ((id_rs_vld and id_rs==ex_rd) or (id_rt_vld and id_rt==ex_rd)): pc_en=0 and ifid_en=0 (hold); idex bubble (en=1, flush=1); exmem and memwb advance.
  - (5) imem_stall: pc_en=0; ifid en=1 and flush=1 (bubble into ID); the rest advance.
  - (6) none of the above: all en=1, all flush=0.
- Branch held during dmem_stall stays asserted, because EX is frozen. It is acted on in the first non-stalled cycle. No latching is needed.
- DRAIN, one cycle: all en=0. Next state=HALTED.
- HALTED: all en=0, halted=1. Only rst leaves this state. All inputs are ignored.
- stall_cycles increments on any cycle with pc_en=0 in RUN/MEM_WAIT. Both counters saturate at all-ones.

Decomposition:
- Shared CPU package/defines file holds the state encodings (2-bit: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3) and the 3-bit register-index width constant.
- One natural sub-module, sat_counter (CNT_W-wide, inc/clr, saturating), is instantiated twice for the performance counters.
- Hazard priority logic stays inline.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_vld=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1; stall_cycles=1. Same stimulus with id_rs_vld=0 -> no stall.
- Branch: branch_taken=1 with imem_stall=1 and a load-use match -> pc_en=1, ifid/idex flush with en=1; flush_count=1; stall_cycles unchanged.
- Mem stall: dmem_stall=1 for 5 cycles with branch_taken=1 throughout -> 5 cycles of pc/ifid/idex/exmem en=0, memwb bubble; cycle 6 (dmem_stall=0) -> branch flush; state RUN; stall_cycles=5.
- Timeout: MEM_TIMEOUT=4, dmem_stall held high -> halted=1 and err_timeout=1 after exactly 4 stall cycles; all en=0 thereafter.
- Halt: halt_mem=1 -> cycle 0: ifid/idex/exmem squashed, memwb advances; cycle 1: DRAIN with all en=0; cycle 2: halted=1. halt_mem asserted together with dmem_stall=1 -> ignored until the stall drops.
- Reset mid-operation: rst=1 while in MEM_WAIT and in HALTED -> next cycle state RUN, halted=0, err_timeout=0, counters=0, all en=1 given idle inputs.
